// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the memory-stage controller and data memory.
interface mem_access_ctrl_if #(
   parameter int DATA_LEN = 32
);
   logic                mem_req_o;
   logic                mem_we_o;
   logic [DATA_LEN-1:0] mem_addr_o;
   logic [DATA_LEN-1:0] mem_wdata_o;
   logic                mem_ack_i;
   logic [DATA_LEN-1:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues loads/stores to data memory and
// freezes the pipeline while an access is outstanding, with ack timeout.
module mem_access_ctrl #(
   parameter int DATA_LEN = 32,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                MemRead_i,
   input  logic                MemWrite_i,
   input  logic [DATA_LEN-1:0] Addr_i,
   input  logic [DATA_LEN-1:0] WriteData_i,
   output logic                Data_Stall_o,
   output logic [DATA_LEN-1:0] ReadData_o,
   output logic                Err_o,
   mem_access_ctrl_if.master   mem_bus
);

   localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [9:0]          r_cnt;
   logic                r_req;
   logic                r_we;
   logic [DATA_LEN-1:0] r_addr;
   logic [DATA_LEN-1:0] r_wdata;
   logic [DATA_LEN-1:0] r_rdata;
   logic                r_err;
   logic                w_req_in;

   assign w_req_in = MemRead_i | MemWrite_i;

   // Stall is combinational so the pipeline freezes in the cycle the request appears.
   assign Data_Stall_o = ((r_state == S_IDLE) & w_req_in) | (r_state == S_BUSY);
   assign ReadData_o   = r_rdata;
   assign Err_o        = r_err;

   assign mem_bus.mem_req_o   = r_req;
   assign mem_bus.mem_we_o    = r_we;
   assign mem_bus.mem_addr_o  = r_addr;
   assign mem_bus.mem_wdata_o = r_wdata;

   // Access FSM with registered bus outputs, wait counter and error pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req_in) begin
                  r_addr  <= Addr_i;
                  r_wdata <= WriteData_i;
                  // load wins when both requests are set
                  r_we    <= MemWrite_i & ~MemRead_i;
                  r_req   <= 1'b1;
                  // cleared and pre-counted: holds n during the nth BUSY cycle
                  r_cnt   <= 10'd1;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (mem_bus.mem_ack_i) begin
                  if (!r_we) begin
                     r_rdata <= mem_bus.mem_rdata_i;
                  end
                  r_req   <= 1'b0;
                  r_state <= S_DONE;
               end else if (r_cnt == TIMEOUT_CNT) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_req   <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 10'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (default and short timeout).
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        rd_a, wr_a, rd_b, wr_b;
   logic [31:0] addr_a, wd_a, addr_b, wd_b;
   logic        stall_a, stall_b, err_a, err_b;
   logic [31:0] rdo_a, rdo_b;
   int          n_chk;
   int          n_fail;

   mem_access_ctrl_if #(.DATA_LEN(32)) bus_a ();
   mem_access_ctrl_if #(.DATA_LEN(32)) bus_b ();

   mem_access_ctrl #(.DATA_LEN(32), .TIMEOUT(255)) dut_a (
      .clk_i(clk), .rst_i(rst), .MemRead_i(rd_a), .MemWrite_i(wr_a),
      .Addr_i(addr_a), .WriteData_i(wd_a), .Data_Stall_o(stall_a),
      .ReadData_o(rdo_a), .Err_o(err_a), .mem_bus(bus_a.master)
   );

   mem_access_ctrl #(.DATA_LEN(32), .TIMEOUT(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .MemRead_i(rd_b), .MemWrite_i(wr_b),
      .Addr_i(addr_b), .WriteData_i(wd_b), .Data_Stall_o(stall_b),
      .ReadData_o(rdo_b), .Err_o(err_b), .mem_bus(bus_b.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_chk++; if (bus_a.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h expected 0", bus_a.mem_req_o); end
      n_chk++; if (bus_a.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h expected 0", bus_a.mem_we_o); end
      n_chk++; if (bus_a.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", bus_a.mem_addr_o); end
      n_chk++; if (bus_a.mem_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", bus_a.mem_wdata_o); end
      n_chk++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h expected 0", err_a); end
      n_chk++; if (rdo_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %0h expected 0", rdo_a); end
      n_chk++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0h expected 0", stall_a); end
      rd_a = 1'b1;
      #1;
      n_chk++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL reset_stall_comb: got %0h expected 1", stall_a); end
      rd_a = 1'b0;
      n_chk++; if (bus_b.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_b: got %0h expected 0", bus_b.mem_req_o); end
      tick();
   endtask

   task automatic test_load();
      // cycle 0: request appears
      rd_a = 1'b1; addr_a = 32'h100;
      #1;
      n_chk++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL load_stall_c0: got %0h expected 1", stall_a); end
      n_chk++; if (bus_a.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL load_req_c0: got %0h expected 0", bus_a.mem_req_o); end
      tick();
      // cycle 1: BUSY, ack arrives
      n_chk++; if (bus_a.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL load_req_c1: got %0h expected 1", bus_a.mem_req_o); end
      n_chk++; if (bus_a.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL load_we_c1: got %0h expected 0", bus_a.mem_we_o); end
      n_chk++; if (bus_a.mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL load_addr_c1: got %0h expected 100", bus_a.mem_addr_o); end
      n_chk++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL load_stall_c1: got %0h expected 1", stall_a); end
      bus_a.mem_ack_i = 1'b1; bus_a.mem_rdata_i = 32'hDEADBEEF;
      tick();
      // cycle 2: DONE, request still held by the frozen pipeline
      bus_a.mem_ack_i = 1'b0; bus_a.mem_rdata_i = 32'h0;
      #1;
      n_chk++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL load_stall_c2: got %0h expected 0", stall_a); end
      n_chk++; if (bus_a.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL load_req_c2: got %0h expected 0", bus_a.mem_req_o); end
      n_chk++; if (rdo_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_c2: got %0h expected deadbeef", rdo_a); end
      rd_a = 1'b0;
      tick();
      // cycle 3: back in IDLE, no request
      n_chk++; if (stall_a !== 1'b0 || bus_a.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL load_idle_c3: got stall=%0h req=%0h expected 0/0", stall_a, bus_a.mem_req_o); end
   endtask

   task automatic test_store();
      int n_stall;
      n_stall = 0;
      wr_a = 1'b1; addr_a = 32'h20; wd_a = 32'h12345678;
      #1;
      if (stall_a === 1'b1) n_stall++;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (stall_a === 1'b1) n_stall++;
         n_chk++; if (bus_a.mem_req_o !== 1'b1 || bus_a.mem_we_o !== 1'b1) begin n_fail++; $display("FAIL store_req_we_c%0d: got req=%0h we=%0h expected 1/1", i, bus_a.mem_req_o, bus_a.mem_we_o); end
         n_chk++; if (bus_a.mem_addr_o !== 32'h20 || bus_a.mem_wdata_o !== 32'h12345678) begin n_fail++; $display("FAIL store_addr_data_c%0d: got %0h/%0h expected 20/12345678", i, bus_a.mem_addr_o, bus_a.mem_wdata_o); end
         if (i == 5) begin
            bus_a.mem_ack_i = 1'b1; bus_a.mem_rdata_i = 32'hA5A5A5A5;
         end
      end
      tick();
      bus_a.mem_ack_i = 1'b0; bus_a.mem_rdata_i = 32'h0;
      #1;
      if (stall_a === 1'b1) n_stall++;
      n_chk++; if (n_stall != 6) begin n_fail++; $display("FAIL store_stall_len: got %0d expected 6", n_stall); end
      n_chk++; if (bus_a.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL store_req_done: got %0h expected 0", bus_a.mem_req_o); end
      n_chk++; if (rdo_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_rdata_kept: got %0h expected deadbeef", rdo_a); end
      wr_a = 1'b0;
      tick();
   endtask

   task automatic test_ack_at_limit();
      // TIMEOUT = 4: ack in BUSY cycle 4 is still accepted
      rd_b = 1'b1; addr_b = 32'h44;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_chk++; if (bus_b.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL limit_req_c%0d: got %0h expected 1", i, bus_b.mem_req_o); end
         if (i == 4) begin
            bus_b.mem_ack_i = 1'b1; bus_b.mem_rdata_i = 32'hCAFEF00D;
         end
      end
      tick();
      bus_b.mem_ack_i = 1'b0; bus_b.mem_rdata_i = 32'h0;
      #1;
      n_chk++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL limit_err: got %0h expected 0", err_b); end
      n_chk++; if (rdo_b !== 32'hCAFEF00D) begin n_fail++; $display("FAIL limit_rdata: got %0h expected cafef00d", rdo_b); end
      n_chk++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL limit_stall: got %0h expected 0", stall_b); end
      rd_b = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      rd_b = 1'b1; addr_b = 32'h48;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_chk++; if (bus_b.mem_req_o !== 1'b1 || stall_b !== 1'b1 || err_b !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_c%0d: got req=%0h stall=%0h err=%0h expected 1/1/0", i, bus_b.mem_req_o, stall_b, err_b); end
      end
      tick();
      // DONE after the 4th BUSY cycle without ack
      n_chk++; if (err_b !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %0h expected 1", err_b); end
      n_chk++; if (rdo_b !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %0h expected 0", rdo_b); end
      n_chk++; if (stall_b !== 1'b0 || bus_b.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL timeout_done: got stall=%0h req=%0h expected 0/0", stall_b, bus_b.mem_req_o); end
      rd_b = 1'b0;
      tick();
      n_chk++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %0h expected 0", err_b); end
   endtask

   task automatic test_back_to_back();
      // cycle 0
      rd_a = 1'b1; addr_a = 32'h200;
      #1;
      n_chk++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_c0: got %0h expected 1", stall_a); end
      tick();
      // cycle 1
      n_chk++; if (bus_a.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL b2b_req_c1: got %0h expected 1", bus_a.mem_req_o); end
      bus_a.mem_ack_i = 1'b1; bus_a.mem_rdata_i = 32'h11111111;
      tick();
      // cycle 2: DONE
      bus_a.mem_ack_i = 1'b0;
      #1;
      n_chk++; if (stall_a !== 1'b0 || rdo_a !== 32'h11111111) begin n_fail++; $display("FAIL b2b_done1: got stall=%0h rdata=%0h expected 0/11111111", stall_a, rdo_a); end
      tick();
      // cycle 3: next instruction presented in IDLE
      addr_a = 32'h204;
      #1;
      n_chk++; if (stall_a !== 1'b1 || bus_a.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_c3: got stall=%0h req=%0h expected 1/0", stall_a, bus_a.mem_req_o); end
      tick();
      // cycle 4: second request on the bus
      n_chk++; if (bus_a.mem_req_o !== 1'b1 || bus_a.mem_addr_o !== 32'h204) begin n_fail++; $display("FAIL b2b_c4: got req=%0h addr=%0h expected 1/204", bus_a.mem_req_o, bus_a.mem_addr_o); end
      bus_a.mem_ack_i = 1'b1; bus_a.mem_rdata_i = 32'h22222222;
      tick();
      // cycle 5: second DONE
      bus_a.mem_ack_i = 1'b0; bus_a.mem_rdata_i = 32'h0;
      #1;
      n_chk++; if (stall_a !== 1'b0 || rdo_a !== 32'h22222222) begin n_fail++; $display("FAIL b2b_done2: got stall=%0h rdata=%0h expected 0/22222222", stall_a, rdo_a); end
      rd_a = 1'b0;
      tick();
   endtask

   task automatic test_spurious_ack();
      bus_a.mem_ack_i = 1'b1; bus_a.mem_rdata_i = 32'h55555555;
      #1;
      n_chk++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL spur_stall: got %0h expected 0", stall_a); end
      tick();
      bus_a.mem_ack_i = 1'b0; bus_a.mem_rdata_i = 32'h0;
      #1;
      n_chk++; if (rdo_a !== 32'h22222222) begin n_fail++; $display("FAIL spur_rdata: got %0h expected 22222222", rdo_a); end
      n_chk++; if (bus_a.mem_req_o !== 1'b0 || stall_a !== 1'b0) begin n_fail++; $display("FAIL spur_state: got req=%0h stall=%0h expected 0/0", bus_a.mem_req_o, stall_a); end
      tick();
   endtask

   task automatic test_reset_busy();
      // cycle 0
      rd_a = 1'b1; addr_a = 32'h300;
      tick();
      // cycle 1
      n_chk++; if (bus_a.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rstb_req_c1: got %0h expected 1", bus_a.mem_req_o); end
      tick();
      // cycle 2: reset asserted
      rst = 1'b1;
      tick();
      // cycle 3: late ack, pipeline flushed
      rst = 1'b0; rd_a = 1'b0;
      bus_a.mem_ack_i = 1'b1; bus_a.mem_rdata_i = 32'h33333333;
      #1;
      n_chk++; if (bus_a.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rstb_req_c3: got %0h expected 0", bus_a.mem_req_o); end
      n_chk++; if (rdo_a !== 32'h0 || stall_a !== 1'b0) begin n_fail++; $display("FAIL rstb_c3: got rdata=%0h stall=%0h expected 0/0", rdo_a, stall_a); end
      tick();
      bus_a.mem_ack_i = 1'b0; bus_a.mem_rdata_i = 32'h0;
      #1;
      n_chk++; if (rdo_a !== 32'h0 || bus_a.mem_req_o !== 1'b0 || stall_a !== 1'b0) begin n_fail++; $display("FAIL rstb_late_ack: got rdata=%0h req=%0h stall=%0h expected 0/0/0", rdo_a, bus_a.mem_req_o, stall_a); end
      tick();
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1;
      rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wd_a = '0;
      rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wd_b = '0;
      bus_a.mem_ack_i = 1'b0; bus_a.mem_rdata_i = '0;
      bus_b.mem_ack_i = 1'b0; bus_b.mem_rdata_i = '0;
      test_reset();
      test_load();
      test_store();
      test_ack_at_limit();
      test_timeout();
      test_back_to_back();
      test_spurious_ack();
      test_reset_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller between the EX/MEM pipeline register and an external data memory with a request/acknowledge handshake. It issues loads and stores to the memory and raises `Data_Stall_o` while an access is outstanding, freezing the pipeline registers. It delivers load data on `ReadData_o`, which the MEM/WB pipeline register captures on the cycle the stall drops. It is the producer of the `Data_Stall` signal that the pipeline registers consume.

## Interface
- `DATA_LEN`, 32: data and address width.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack_i` before aborting; range 1..1023.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `MemRead_i`  in  1  load request from EX/MEM.
- `MemWrite_i`  in  1  store request from EX/MEM.
- `Addr_i`  in  DATA_LEN  byte address (ALU result).
- `WriteData_i`  in  DATA_LEN  store data.
- `Data_Stall_o`  out  1  pipeline freeze request.
- `ReadData_o`  out  DATA_LEN  load data to MEM/WB.
- `Err_o`  out  1  one-cycle pulse when an access timed out.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  DATA_LEN  memory address.
- `mem_wdata_o`  out  DATA_LEN  memory write data.
- `mem_ack_i`  in  1  memory completion, single-cycle pulse.
- `mem_rdata_i`  in  DATA_LEN  read data, valid when `mem_ack_i` = 1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `MemRead_i | MemWrite_i`: latch `Addr_i`, `WriteData_i` and `we = MemWrite_i` into request registers; go to BUSY; clear the wait counter.
  - A load has priority if both requests are set; `we` = 0 in that case.
- **BUSY**
  - `mem_req_o` = 1; `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are driven from the latched registers and are stable for the whole state.
  - The wait counter increments each cycle.
  - On `mem_ack_i`: capture `mem_rdata_i` into the read-data register (loads only; a store leaves it unchanged) and go to DONE.
  - If the counter reaches `TIMEOUT` without an ack: go to DONE, set the read-data register to 0 and pulse `Err_o` in the DONE cycle.
- **DONE**
  - `Data_Stall_o` = 0 so the pipeline advances at this edge.
  - Next state is always IDLE.
  - Request inputs present during DONE belong to the finishing instruction and are ignored.
- `Data_Stall_o` = (IDLE & (`MemRead_i` | `MemWrite_i`)) | BUSY. It is combinational so it asserts in the same cycle the request appears.
- `ReadData_o` = the read-data register at all times.
- `mem_ack_i` outside BUSY is ignored.
- `mem_req_o` = 0 in IDLE and DONE.

## Timing
- Reset (at edge with `rst_i` = 1):
  - state IDLE; counter and read-data register 0.
  - `mem_req_o`, `mem_we_o`, `Err_o` = 0; `mem_addr_o`, `mem_wdata_o` = 0.
  - `Data_Stall_o` follows its combinational definition from IDLE.
- Reset during BUSY aborts the access: `mem_req_o` drops in the cycle after the reset edge, and a late ack is ignored.
- Latency, with the request seen in cycle 0:
  - BUSY from cycle 1.
  - If the ack arrives in cycle k (k ≥ 1), DONE is cycle k+1 and the pipeline advances at the end of cycle k+1.
  - Total stall = k+1 cycles; minimum stall is 2 cycles (ack in cycle 1).
- Timeout:
  - The counter equals n during the nth BUSY cycle.
  - With `TIMEOUT` = T, an ack in BUSY cycle T is still accepted.
  - If there is no ack by then, DONE follows and `Err_o` pulses for exactly 1 cycle.
- Back-to-back accesses: the IDLE cycle after DONE may immediately start the next request, so there is no dead cycle between consecutive memory instructions.
- Counter width is 10 bits and never wraps because BUSY exits at T ≤ 1023.

## Test plan
- Load, `Addr_i` = 0x100, ack in BUSY cycle 1 with rdata 0xDEADBEEF:
  - `mem_req_o` = 1, `mem_we_o` = 0 and `mem_addr_o` = 0x100 for 1 cycle.
  - `Data_Stall_o` high for cycles 0–1, low in cycle 2.
  - `ReadData_o` = 0xDEADBEEF in cycle 2.
- Store, `Addr_i` = 0x20, data 0x12345678, ack after 5 cycles: `mem_we_o` = 1 with stable address/data for 5 cycles; stall lasts 6 cycles; `ReadData_o` unchanged.
- `TIMEOUT` = 4 and no ack: 4 BUSY cycles, `Err_o` pulses 1 cycle, `ReadData_o` = 0, stall drops in DONE.
- Back-to-back loads, each acked in cycle 1: second `mem_req_o` rises 2 cycles after the first DONE; each stall lasts 2 cycles.
- Reset asserted in BUSY cycle 2, then ack in cycle 3: `mem_req_o` = 0 from cycle 3, state IDLE, `ReadData_o` = 0, late ack ignored.
- Spurious `mem_ack_i` in IDLE with no request: no state change, `Data_Stall_o` = 0, `ReadData_o` unchanged.
